// File: rtl/eb1_bp_ghr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : eb1_bp_ghr_ctl
// Brief    : Speculative / retired global-history controller with per-branch
//            GHR checkpoints for misprediction recovery.
// Revision : 1.0 - initial release
// ============================================================================
module eb1_bp_ghr_ctl #(
    parameter int GHR_SIZE   = 8,
    parameter int CKPT_DEPTH = 4,
    parameter int TAG_W      = $clog2(CKPT_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic                pred_taken,
    output logic                pred_ready,
    output logic [TAG_W-1:0]    pred_tag,
    input  logic                ret_valid,
    input  logic                ret_taken,
    input  logic                flush_valid,
    input  logic [TAG_W-1:0]    flush_tag,
    input  logic                flush_taken,
    input  logic                flush_all,
    output logic [GHR_SIZE-1:0] ghr,
    output logic [GHR_SIZE-1:0] ghr_ret,
    output logic [TAG_W:0]      count,
    output logic                err
);

    localparam logic [TAG_W:0] c_depth = (TAG_W+1)'(CKPT_DEPTH);
    localparam logic [TAG_W:0] c_one   = (TAG_W+1)'(1);

    function automatic logic [GHR_SIZE-1:0] f_sh(input logic [GHR_SIZE-1:0] h,
                                                 input logic                b);
        return {h[GHR_SIZE-2:0], b};
    endfunction

    logic [GHR_SIZE-1:0] r_ckpt [CKPT_DEPTH];
    logic [GHR_SIZE-1:0] r_ghr;
    logic [GHR_SIZE-1:0] r_ghr_ret;
    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    logic                r_err;

    logic [TAG_W:0]      w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_pred_acc;
    logic                w_ret_ok;
    logic [TAG_W-1:0]    w_off;
    logic                w_flush_ok;
    logic [GHR_SIZE-1:0] w_ghr_nxt;
    logic [GHR_SIZE-1:0] w_ghr_ret_nxt;
    logic [TAG_W:0]      w_head_nxt;
    logic [TAG_W:0]      w_tail_nxt;
    logic                w_err_nxt;

    assign w_count    = r_tail - r_head;
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (w_count == c_depth);
    assign pred_ready = !w_full && !flush_valid && !flush_all;
    assign w_pred_acc = pred_valid && pred_ready;
    assign w_ret_ok   = ret_valid && !w_empty;

    // Offset of the flushed tag from the oldest entry; valid only inside the occupied window.
    assign w_off      = flush_tag - r_head[TAG_W-1:0];
    assign w_flush_ok = ({1'b0, w_off} < w_count);

    always_comb begin
        w_head_nxt    = w_ret_ok ? (r_head + c_one) : r_head;
        w_ghr_ret_nxt = w_ret_ok ? f_sh(r_ghr_ret, ret_taken) : r_ghr_ret;
        w_ghr_nxt     = r_ghr;
        w_tail_nxt    = r_tail;
        w_err_nxt     = ret_valid && w_empty;
        if (flush_all) begin
            w_ghr_nxt  = w_ghr_ret_nxt;
            w_tail_nxt = w_head_nxt;
        end else if (flush_valid) begin
            if (w_flush_ok) begin
                w_ghr_nxt  = f_sh(r_ckpt[flush_tag], flush_taken);
                // Rebuilt from head so the wrap bit stays consistent with the occupancy.
                w_tail_nxt = r_head + {1'b0, w_off} + c_one;
            end else begin
                w_err_nxt  = 1'b1;
            end
        end else if (w_pred_acc) begin
            w_ghr_nxt  = f_sh(r_ghr, pred_taken);
            w_tail_nxt = r_tail + c_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr     <= '0;
            r_ghr_ret <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ghr     <= w_ghr_nxt;
            r_ghr_ret <= w_ghr_ret_nxt;
            r_head    <= w_head_nxt;
            r_tail    <= w_tail_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Checkpoint payload is only meaningful inside the head/tail window, so no reset.
    always_ff @(posedge clk) begin
        if (w_pred_acc) begin
            r_ckpt[r_tail[TAG_W-1:0]] <= r_ghr;
        end
    end

    assign pred_tag = r_tail[TAG_W-1:0];
    assign ghr      = r_ghr;
    assign ghr_ret  = r_ghr_ret;
    assign count    = w_count;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_eb1_bp_ghr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eb1_bp_ghr_ctl
// Brief    : Directed self-checking bench for eb1_bp_ghr_ctl (8-bit GHR, 4 ckpts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_eb1_bp_ghr_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pred_valid = 1'b0, pred_taken = 1'b0, pred_ready;
    logic [1:0] pred_tag;
    logic       ret_valid = 1'b0, ret_taken = 1'b0;
    logic       flush_valid = 1'b0, flush_taken = 1'b0, flush_all = 1'b0;
    logic [1:0] flush_tag = 2'd0;
    logic [7:0] ghr, ghr_ret;
    logic [2:0] count;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    eb1_bp_ghr_ctl #(.GHR_SIZE(8), .CKPT_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag),
        .ret_valid(ret_valid), .ret_taken(ret_taken),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .flush_taken(flush_taken), .flush_all(flush_all),
        .ghr(ghr), .ghr_ret(ghr_ret), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        pred_valid = 0; pred_taken = 0; ret_valid = 0; ret_taken = 0;
        flush_valid = 0; flush_tag = 0; flush_taken = 0; flush_all = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({ghr, ghr_ret, count, pred_ready, err, pred_tag} !== {8'h00, 8'h00, 3'd0, 1'b1, 1'b0, 2'd0}) begin
            $display("FAIL reset: ghr=%h ghr_ret=%h count=%0d rdy=%b err=%b tag=%0d, want 00 00 0 1 0 0",
                     ghr, ghr_ret, count, pred_ready, err, pred_tag);
            n_err++;
        end
    endtask

    task automatic test_fill_and_flush();
        logic b [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1; pred_taken = b[i];
            #1;
            n_vec++;
            if ({pred_ready, pred_tag} !== {1'b1, 2'(i)}) begin
                $display("FAIL fill_tag%0d: rdy=%b tag=%0d, want 1 %0d", i, pred_ready, pred_tag, i);
                n_err++;
            end
            tick();
        end
        idle(); #1;
        n_vec++;
        if ({ghr, count, pred_ready} !== {8'h0B, 3'd4, 1'b0}) begin
            $display("FAIL fill_full: ghr=%h count=%0d rdy=%b, want 0b 4 0", ghr, count, pred_ready);
            n_err++;
        end
        pred_valid = 1; pred_taken = 1;
        tick();
        idle();
        n_vec++;
        if ({ghr, count, err} !== {8'h0B, 3'd4, 1'b0}) begin
            $display("FAIL drop_when_full: ghr=%h count=%0d err=%b, want 0b 4 0", ghr, count, err);
            n_err++;
        end
        flush_valid = 1; flush_tag = 2'd1; flush_taken = 1;
        tick();
        idle(); #1;
        n_vec++;
        if ({ghr, count, pred_tag, err, pred_ready} !== {8'h03, 3'd2, 2'd2, 1'b0, 1'b1}) begin
            $display("FAIL flush_tag1: ghr=%h count=%0d tag=%0d err=%b rdy=%b, want 03 2 2 0 1",
                     ghr, count, pred_tag, err, pred_ready);
            n_err++;
        end
    endtask

    task automatic test_flush_all();
        do_reset();
        pred_valid = 1; pred_taken = 1; tick();
        pred_taken = 0; tick();
        idle(); ret_valid = 1; ret_taken = 1; tick();
        n_vec++;
        if ({ghr_ret, count} !== {8'h01, 3'd1}) begin
            $display("FAIL retire_first: ghr_ret=%h count=%0d, want 01 1", ghr_ret, count);
            n_err++;
        end
        ret_taken = 0; tick();
        idle();
        pred_valid = 1; pred_taken = 1; flush_all = 1;
        #1;
        n_vec++;
        if (pred_ready !== 1'b0) begin
            $display("FAIL flush_all_blocks_pred: rdy=%b, want 0", pred_ready);
            n_err++;
        end
        tick();
        idle(); #1;
        n_vec++;
        if ({ghr_ret, ghr, count, pred_tag} !== {8'h02, 8'h02, 3'd0, 2'd2}) begin
            $display("FAIL flush_all: ghr_ret=%h ghr=%h count=%0d tag=%0d, want 02 02 0 2",
                     ghr_ret, ghr, count, pred_tag);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic       b   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp [6] = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2D};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pred_valid = 1; pred_taken = b[i];
            #1;
            n_vec++;
            if (pred_tag !== 2'(i % 4)) begin
                $display("FAIL b2b_tag%0d: tag=%0d, want %0d", i, pred_tag, i % 4);
                n_err++;
            end
            tick();
            idle();
            n_vec++;
            if ({ghr, count} !== {exp[i], 3'd1}) begin
                $display("FAIL b2b_pred%0d: ghr=%h count=%0d, want %h 1", i, ghr, count, exp[i]);
                n_err++;
            end
            ret_valid = 1; ret_taken = b[i];
            tick();
            idle();
            n_vec++;
            if ({ghr_ret, ghr, count, err} !== {exp[i], exp[i], 3'd0, 1'b0}) begin
                $display("FAIL b2b_ret%0d: ghr_ret=%h ghr=%h count=%0d err=%b, want %h %h 0 0",
                         i, ghr_ret, ghr, count, err, exp[i], exp[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_errors();
        do_reset();
        ret_valid = 1; ret_taken = 1;
        tick();
        idle();
        n_vec++;
        if ({err, ghr_ret, count} !== {1'b1, 8'h00, 3'd0}) begin
            $display("FAIL ret_empty: err=%b ghr_ret=%h count=%0d, want 1 00 0", err, ghr_ret, count);
            n_err++;
        end
        pred_valid = 1; pred_taken = 1;
        tick();
        idle();
        n_vec++;
        if ({err, ghr, count} !== {1'b0, 8'h01, 3'd1}) begin
            $display("FAIL err_single_pulse: err=%b ghr=%h count=%0d, want 0 01 1", err, ghr, count);
            n_err++;
        end
        flush_valid = 1; flush_tag = 2'd2; flush_taken = 1;
        tick();
        idle();
        n_vec++;
        if ({err, ghr, ghr_ret, count} !== {1'b1, 8'h01, 8'h00, 3'd1}) begin
            $display("FAIL bad_flush: err=%b ghr=%h ghr_ret=%h count=%0d, want 1 01 00 1",
                     err, ghr, ghr_ret, count);
            n_err++;
        end
        tick();
        n_vec++;
        if (err !== 1'b0) begin
            $display("FAIL bad_flush_pulse: err=%b, want 0", err);
            n_err++;
        end
        // Retire and flush the same oldest entry together: ckpt[0]=00.
        ret_valid = 1; ret_taken = 1;
        flush_valid = 1; flush_tag = 2'd0; flush_taken = 0;
        tick();
        idle();
        n_vec++;
        if ({ghr, ghr_ret, count, err, pred_tag} !== {8'h00, 8'h01, 3'd0, 1'b0, 2'd1}) begin
            $display("FAIL ret_flush_same: ghr=%h ghr_ret=%h count=%0d err=%b tag=%0d, want 00 01 0 0 1",
                     ghr, ghr_ret, count, err, pred_tag);
            n_err++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        pred_valid = 1; pred_taken = 1; tick(); tick();
        idle();
        #2 rst = 1;
        #1;
        n_vec++;
        if ({ghr, count, pred_ready, pred_tag} !== {8'h00, 3'd0, 1'b1, 2'd0}) begin
            $display("FAIL async_reset: ghr=%h count=%0d rdy=%b tag=%0d, want 00 0 1 0",
                     ghr, count, pred_ready, pred_tag);
            n_err++;
        end
        #1 rst = 0;
    endtask

    initial begin
        test_reset();
        test_fill_and_flush();
        test_flush_all();
        test_back_to_back();
        test_errors();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
